// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: strobed RW control registers, RO status registers,
// a W1C interrupt-pending register, an interrupt-enable register and a registered irq output.
module axi_lite_regbank #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STAT           = 2,
    parameter int          IRQ_W              = 8,
    parameter logic [31:0] CTRL_RST_VAL       = 32'h0000_0000,
    localparam int         STAT_N             = (NUM_STAT > 0) ? NUM_STAT : 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*NUM_CTRL-1:0]          ctrl_out,
    input  logic [32*STAT_N-1:0]            status_in,
    input  logic [IRQ_W-1:0]                irq_event_in,
    output logic                            irq_out
);

    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int PEND_IDX = NUM_CTRL + NUM_STAT;
    localparam int EN_IDX   = PEND_IDX + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic             clk;
    logic             srst;
    assign clk  = S_AXI_ACLK;
    assign srst = S_AXI_ARESET;

    logic             aw_held_reg;
    logic [IDX_W-1:0] aw_idx_reg;
    logic             w_held_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wstrb_reg;
    logic             bvalid_reg;
    logic [1:0]       bresp_reg;
    logic             rvalid_reg;
    logic [31:0]      rdata_reg;
    logic [1:0]       rresp_reg;
    logic [IRQ_W-1:0] pend_reg;
    logic [IRQ_W-1:0] en_reg;
    logic             irq_reg;

    logic [IRQ_W-1:0] pend_next;
    logic [IRQ_W-1:0] en_next;
    logic [31:0]      wr_idx;
    logic [31:0]      rd_idx;
    logic [31:0]      wmask;
    logic [31:0]      wbits;
    logic [31:0]      en_merged;
    logic [31:0]      rd_data;
    logic             rd_err;
    logic             wr_err;
    logic             commit;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;

    // Readies are held low while reset is asserted so nothing handshakes during reset.
    assign S_AXI_AWREADY = !aw_held_reg && !bvalid_reg && !srst;
    assign S_AXI_WREADY  = !w_held_reg && !bvalid_reg && !srst;
    assign S_AXI_ARREADY = !rvalid_reg && !srst;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign irq_out       = irq_reg;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_held_reg && w_held_reg && !bvalid_reg;

    assign wr_idx = 32'(aw_idx_reg);
    assign rd_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign wr_err = wr_idx > 32'(EN_IDX);
    assign wmask  = {{8{wstrb_reg[3]}}, {8{wstrb_reg[2]}}, {8{wstrb_reg[1]}}, {8{wstrb_reg[0]}}};
    assign wbits  = wdata_reg & wmask;

    wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write address / data holding registers and the B channel.
    always_ff @(posedge clk) begin
        if (srst) begin
            aw_held_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_held_reg  <= 1'b0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= S_AXI_WDATA[31:0];
                wstrb_reg  <= S_AXI_WSTRB;
            end
            if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
            logic [31:0] value_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    value_reg <= CTRL_RST_VAL;
                end else if (commit && (wr_idx == 32'(gi))) begin
                    value_reg <= (value_reg & ~wmask) | wbits;
                end
            end
            assign ctrl_out[32*gi +: 32] = value_reg;
        end
    endgenerate

    // Events are applied after the W1C clear so a same-cycle event keeps its bit set.
    always_comb begin
        en_merged = 32'(en_reg);
        en_merged = (en_merged & ~wmask) | wbits;
        pend_next = pend_reg | irq_event_in;
        en_next   = en_reg;
        if (commit && (wr_idx == 32'(PEND_IDX))) begin
            pend_next = (pend_reg & ~wbits[IRQ_W-1:0]) | irq_event_in;
        end
        if (commit && (wr_idx == 32'(EN_IDX))) begin
            en_next = en_merged[IRQ_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pend_reg <= '0;
            en_reg   <= '0;
            irq_reg  <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            en_reg   <= en_next;
            irq_reg  <= |(pend_next & en_next);
        end
    end

    // Read mux sees register state before any same-edge commit.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_data = ctrl_out[32*i +: 32];
            end
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (rd_idx == 32'(NUM_CTRL + i)) begin
                rd_data = status_in[32*i +: 32];
            end
        end
        if (rd_idx == 32'(PEND_IDX)) begin
            rd_data[IRQ_W-1:0] = pend_reg;
        end
        if (rd_idx == 32'(EN_IDX)) begin
            rd_data[IRQ_W-1:0] = en_reg;
        end
        if (rd_idx > 32'(EN_IDX)) begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with a transaction-level register model and
// a per-cycle compare of ctrl_out / irq_out against that model.
module tb_axi_lite_regbank;

    localparam int NC   = 4;
    localparam int NS   = 2;
    localparam int IW   = 8;
    localparam int PEND = NC + NS;
    localparam int EN   = PEND + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [7:0]      araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [32*NC-1:0] ctrl_out;
    logic [32*NS-1:0] status_in = {32'h0000_5A5A, 32'hBEEF_0011};
    logic [IW-1:0]   irq_event_in = '0;
    logic            irq_out;

    int checks = 0;
    int errors = 0;

    logic [31:0]   ctrl_m [NC];
    logic [IW-1:0] pend_m;
    logic [IW-1:0] en_m;
    bit            model_ok = 0;

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_CTRL(NC),
        .NUM_STAT(NS), .IRQ_W(IW), .CTRL_RST_VAL(32'h0000_0000)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_out(ctrl_out), .status_in(status_in), .irq_event_in(irq_event_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32*NC-1:0] ctrl_flat();
        logic [32*NC-1:0] f;
        for (int i = 0; i < NC; i++) f[32*i +: 32] = ctrl_m[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) ctrl_m[i] = 32'h0;
        pend_m = '0;
        en_m   = '0;
    endtask

    task automatic exp_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        d = 32'h0;
        r = 2'b00;
        if (idx < NC) d = ctrl_m[idx];
        else if (idx < NC + NS) d = status_in[32*(idx-NC) +: 32];
        else if (idx == PEND) d = 32'(pend_m);
        else if (idx == EN) d = 32'(en_m);
        else r = 2'b10;
    endtask

    // Per-cycle compare of the always-visible outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("ctrl_out", ctrl_out[31:0], ctrl_flat() >> 0);
            check("ctrl_out_hi", ctrl_out[32*NC-1:32*NC-32], ctrl_m[NC-1]);
            checks++;
            if (ctrl_out !== ctrl_flat()) begin
                errors++;
                $display("FAIL ctrl_out_all actual=%h required=%h", ctrl_out, ctrl_flat());
            end
            check("irq_out", irq_out, |(pend_m & en_m));
        end
    end

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int hold,
                             input logic [IW-1:0] pulse);
        bit aw_done, w_done, aw_f, w_f;
        int c;
        logic [31:0] m;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge clk);
            awaddr  = 8'(idx * 4);
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            aw_f    = awvalid && awready;
            w_f     = wvalid && wready;
            @(posedge clk);
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            c++;
        end
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", {30'd0, aw_done, w_done}, 32'd3);
        if (!(aw_done && w_done)) return;
        irq_event_in = pulse;
        @(posedge clk);
        #1;
        irq_event_in = '0;
        check("bvalid_latency", bvalid, 1'b1);
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx < NC) ctrl_m[idx] = (ctrl_m[idx] & ~m) | (data & m);
        else if (idx == PEND) pend_m = pend_m & ~IW'(data & m);
        else if (idx == EN) en_m = IW'((32'(en_m) & ~m) | (data & m));
        pend_m = pend_m | pulse;
        exp_resp = (idx > EN) ? 2'b10 : 2'b00;
        check("bresp", bresp, exp_resp);
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, exp_resp);
        end
        @(negedge clk);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
        $display("WR idx=%0d data=%h strb=%b pulse=%h resp=%b", idx, data, strb, pulse, exp_resp);
    endtask

    task automatic axi_read(input int idx, input int hold, output logic [31:0] d);
        int n;
        logic [31:0] ed;
        logic [1:0] er;
        @(negedge clk);
        araddr  = 8'(idx * 4);
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready_timeout", arready, 1'b1);
        exp_read(idx, ed, er);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        check("rvalid_latency", rvalid, 1'b1);
        d = rdata;
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        repeat (hold) begin
            @(negedge clk);
            check("rdata_hold", rdata, ed);
            check("rvalid_hold", rvalid, 1'b1);
        end
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
        $display("RD idx=%0d data=%h exp=%h resp_exp=%b", idx, d, ed, er);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        model_ok = 1;
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_irq", irq_out, 1'b0);
        check("rst_ctrl0", ctrl_out[31:0], 32'h0);
        check("rst_awready", awready, 1'b0);
        check("rst_bresp_rresp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        do_reset();

        for (int i = 0; i <= EN; i++) axi_read(i, 0, rd);
        axi_read(0, 0, rd);
        check("lit_ctrl0_reset", rd, 32'h0000_0000);

        axi_write(0, 32'h0101_FFFF, 4'hF, 0, 0, 0, '0);
        axi_read(0, 0, rd);
        check("lit_ctrl0_rb", rd, 32'h0101_FFFF);
        check("lit_ctrl_out0", ctrl_out[31:0], 32'h0101_FFFF);

        axi_write(1, 32'hABCD_0001, 4'hF, 0, 0, 0, '0);
        axi_write(1, 32'hDEAD_BEEF, 4'b0101, 0, 0, 5, '0);
        axi_read(1, 2, rd);
        check("lit_strobe", rd, 32'hABAD_00EF);

        axi_write(2, 32'h1111_2222, 4'hF, 3, 0, 0, '0);
        axi_write(3, 32'h3333_4444, 4'hF, 0, 3, 1, '0);
        axi_read(2, 0, rd);
        check("lit_w_first", rd, 32'h1111_2222);
        axi_read(3, 0, rd);
        check("lit_aw_first", rd, 32'h3333_4444);

        axi_read(NC, 0, rd);
        check("lit_stat0", rd, 32'hBEEF_0011);
        axi_write(NC, 32'h0000_0000, 4'hF, 0, 0, 0, '0);
        axi_read(NC + 1, 0, rd);
        check("lit_stat1", rd, 32'h0000_5A5A);
        axi_read(63, 0, rd);
        check("lit_unmapped_rd", rd, 32'h0);
        axi_write(63, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, '0);
        axi_read(0, 0, rd);
        check("lit_unmapped_nochange", rd, 32'h0101_FFFF);

        axi_write(EN, 32'h0000_0005, 4'hF, 0, 0, 0, '0);
        @(negedge clk);
        irq_event_in = 8'h01;
        @(posedge clk);
        #1;
        pend_m = pend_m | 8'h01;
        irq_event_in = '0;
        @(negedge clk);
        check("lit_irq_set", irq_out, 1'b1);
        axi_read(PEND, 0, rd);
        check("lit_pend_set", rd, 32'h01);
        axi_write(PEND, 32'h0000_0001, 4'hF, 0, 0, 0, 8'h01);
        axi_read(PEND, 0, rd);
        check("lit_pend_set_wins", rd, 32'h01);
        axi_write(PEND, 32'h0000_0001, 4'hF, 0, 0, 0, '0);
        axi_read(PEND, 0, rd);
        check("lit_pend_clear", rd, 32'h00);
        check("lit_irq_clear", irq_out, 1'b0);
        axi_write(EN, 32'hFFFF_FF02, 4'h3, 0, 0, 0, 8'h02);
        axi_read(EN, 0, rd);
        check("lit_en_masked", rd, 32'h0000_0002);

        // Leave a B and an R response pending, then reset over them.
        @(negedge clk);
        awaddr = 8'(2 * 4); wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h0; arvalid = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk);
        #1;
        ctrl_m[2] = 32'h1234_5678;
        check("pre_rst_bvalid", bvalid, 1'b1);
        check("pre_rst_rvalid", rvalid, 1'b1);
        do_reset();
        check("post_rst_ctrl2", ctrl_out[95:64], 32'h0);
        @(negedge clk);
        check("post_rst_awready", awready, 1'b1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. It is the next-generation system-controller register block.
- Provides NUM_CTRL read/write control registers with byte strobes and NUM_STAT read-only status registers.
- Provides a write-1-to-clear interrupt pending register, an interrupt enable register and a combined interrupt output.
- Sits between the PS AXI GP master and the converter control logic. Out-of-map accesses return SLVERR.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUM_CTRL+NUM_STAT+2.
- NUM_CTRL, 4, number of RW control registers (1..32).
- NUM_STAT, 2, number of RO status registers (0..32).
- IRQ_W, 8, number of interrupt sources (1..32).
- CTRL_RST_VAL, 32'h0000_0000, reset value of every control register.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32  / S_AXI_WSTRB  in  4  / S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2  / S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  / S_AXI_ARPROT  in  3 (ignored)  / S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32  / S_AXI_RRESP  out  2  / S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1.
- ctrl_out  out  32*NUM_CTRL  control register contents; reg k occupies bits [32k+31:32k].
- status_in  in  32*NUM_STAT  status values, sampled at read time.
- irq_event_in  in  IRQ_W  per-source set pulses, level-sampled every cycle.
- irq_out  out  1  registered OR of (pending & enable).

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESET is synchronous, active-high.
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, ctrl regs CTRL_RST_VAL, IRQ_PEND 0, IRQ_EN 0, irq_out 0.
- Reset mid-transaction: any held AW/W/AR and any pending B/R are dropped; no register is written.
- Register index: idx = addr[C_S_AXI_ADDR_WIDTH-1:2]. addr[1:0] is ignored.
  - idx 0..NUM_CTRL-1: CTRL, RW with strobes.
  - idx NUM_CTRL..NUM_CTRL+NUM_STAT-1: STAT, RO.
  - idx NUM_CTRL+NUM_STAT: IRQ_PEND, W1C. Bits >= IRQ_W read 0.
  - idx NUM_CTRL+NUM_STAT+1: IRQ_EN, RW with strobes. Bits >= IRQ_W read 0 and are not stored.
  - Higher idx: unmapped.
- Write path:
  - AW and W are accepted independently, in any order, and held in separate 1-deep holding regs.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - Commit cycle is the first edge where aw_held && w_held && !BVALID. That edge writes the target, sets BVALID and clears both held flags.
  - Latency: AW+W handshake at edge N gives BVALID at edge N+1.
  - BVALID stays high until BREADY is sampled high. No new AW/W is accepted while BVALID is high, so at most 1 write is outstanding.
  - CTRL/IRQ_EN: byte j is updated only if WSTRB[j]=1.
  - IRQ_PEND: bits set in WDATA within strobed bytes are cleared. If irq_event_in[i] is high in the commit cycle, the set wins and the bit stays 1.
  - STAT: data is discarded, BRESP=OKAY (2'b00).
  - Unmapped: no state change, BRESP=SLVERR (2'b10).
- Read path:
  - ARREADY = !RVALID. AR handshake at edge N loads RDATA/RRESP and sets RVALID at edge N+1.
  - RDATA and RRESP are stable while RVALID && !RREADY.
  - RVALID clears on the RREADY handshake. Back-to-back reads give at most one read per 2 cycles.
  - STAT returns status_in as sampled in the handshake cycle.
  - Unmapped: RDATA=0, RRESP=SLVERR.
- Read/write concurrency: read and write paths are independent. A read of a register committed on the same edge returns the old value.
- IRQ:
  - Every cycle: pend <= (pend & ~clr_mask) | irq_event_in.
  - irq_out <= |(pend_next & en_next). It is 1 cycle after pend/en change and is held until cleared.
- ctrl_out is driven directly from the CTRL regs and updates at the commit edge.

Test Plan:
- Reset, then read idx 0..NUM_CTRL+NUM_STAT+1 -> CTRL read 0, IRQ regs read 0, all RRESP=OKAY. An out-of-reset write of 32'h0101FFFF to idx0 gives read-back 0x0101FFFF and ctrl_out[31:0]=0x0101FFFF.
- Strobes: CTRL1=0xABCD0001, then write 0xDEADBEEF with WSTRB=4'b0101 -> reads 0xABAD00EF. BRESP=OKAY, BVALID held while BREADY is held low for 5 cycles.
- Write ordering: W presented 3 cycles before AW, and separately AW 3 cycles before W -> each commits exactly once, BVALID one cycle after the later handshake, data correct.
- Status/unmapped: with status_in[31:0]=0xBEEF0011, a read of idx NUM_CTRL returns 0xBEEF0011/OKAY. A write to that idx has no effect. Read or write at idx 63 gives SLVERR, RDATA=0, no state change.
- IRQ: IRQ_EN=0x05, pulse irq_event_in=0x01 -> PEND=0x01, irq_out=1. W1C 0x01 in the same cycle as a new pulse of bit 0 -> PEND stays 0x01. A later W1C without a pulse -> PEND=0, and irq_out falls the next cycle.
- Assert S_AXI_ARESET while BVALID=1 and RVALID=1 with BREADY=RREADY=0 -> next edge all VALIDs 0, ctrl_out=CTRL_RST_VAL, irq_out=0.
